// File: rtl/alu_hazard_scheduler.sv
// ALU issue scheduler: tracks in-flight destinations, stalls on RAW/WAW hazards, supports pipeline drain.
// Optional feature: define ALU_HAZARD_FWD_EN to assume forwarding from stages 2..DEPTH (RAW checks stage 1 only).
module alu_hazard_scheduler #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [6:0]       opcode,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic [4:0]       dest,
  input  logic             drain,
  output logic             stall,
  output logic             issue,
  output logic             wb_valid,
  output logic [4:0]       wb_dest,
  output logic             drain_done,
  output logic [CNT_W-1:0] stall_cnt
);

`ifdef ALU_HAZARD_FWD_EN
  localparam int RAW_STAGES = 1;
`else
  localparam int RAW_STAGES = DEPTH;
`endif

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t         state, state_next;
  logic [DEPTH-1:0] trk_v;
  logic [4:0]     trk_dest [DEPTH];
  logic           raw_hit, waw_hit, hazard, chain_empty;

  // The opcode travels with the instruction to the ALU; the scheduler itself never inspects it.
  logic unused_opcode;
  assign unused_opcode = ^opcode;

  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (trk_v[k] && (trk_dest[k] != 5'd0)) begin
        if ((k < RAW_STAGES) && ((trk_dest[k] == src1) || (trk_dest[k] == src2)))
          raw_hit = 1'b1;
        if (trk_dest[k] == dest)
          waw_hit = 1'b1;
      end
    end
  end

  assign hazard      = raw_hit | waw_hit;
  assign chain_empty = ~|trk_v;

  // A drain request in RUN blocks issue in the same cycle it is seen.
  assign stall      = valid & (hazard | (state != RUN) | drain);
  assign issue      = valid & ~stall;
  assign wb_valid   = trk_v[DEPTH-1];
  assign wb_dest    = trk_v[DEPTH-1] ? trk_dest[DEPTH-1] : 5'd0;
  assign drain_done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_v <= '0;
      for (int k = 0; k < DEPTH; k++)
        trk_dest[k] <= 5'd0;
    end else begin
      trk_v       <= {trk_v[DEPTH-2:0], issue};
      trk_dest[0] <= dest;
      for (int k = 1; k < DEPTH; k++)
        trk_dest[k] <= trk_dest[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= RUN;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (drain) state_next = DRAIN;
      DRAIN:   if (chain_empty) state_next = DONE;
      DONE:    state_next = drain ? DRAIN : RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_alu_hazard_scheduler.sv
// Directed self-checking bench for alu_hazard_scheduler (default DEPTH=3, CNT_W=16).
module tb_alu_hazard_scheduler;

`ifdef ALU_HAZARD_FWD_EN
  localparam int DEP_STALLS = 1;
`else
  localparam int DEP_STALLS = 3;
`endif

  logic        clk, rst, valid, drain;
  logic [6:0]  opcode;
  logic [4:0]  src1, src2, dest;
  logic        stall, issue, wb_valid, drain_done;
  logic [4:0]  wb_dest;
  logic [15:0] stall_cnt;

  int checks = 0;
  int fails  = 0;
  int exp_cnt = 0;

  alu_hazard_scheduler #(.DEPTH(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .valid(valid), .opcode(opcode),
    .src1(src1), .src2(src2), .dest(dest), .drain(drain),
    .stall(stall), .issue(issue), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .drain_done(drain_done), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [4:0] d, input logic dr);
    valid  = v;
    opcode = 7'h33;
    src1   = s1;
    src2   = s2;
    dest   = d;
    drain  = dr;
  endtask

  // Checks one cycle mid-period, then advances to just after the next rising edge.
  task automatic checkCycle(input string tag, input logic e_stall, input logic e_issue,
                            input logic e_wbv, input logic [4:0] e_wbd, input logic e_dd);
    @(negedge clk);
    checkOutput({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
    checkOutput({tag, ".issue"}, {31'd0, issue}, {31'd0, e_issue});
    checkOutput({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, e_wbv});
    if (e_wbv)
      checkOutput({tag, ".wb_dest"}, {27'd0, wb_dest}, {27'd0, e_wbd});
    checkOutput({tag, ".drain_done"}, {31'd0, drain_done}, {31'd0, e_dd});
    checkOutput({tag, ".stall_cnt"}, {16'd0, stall_cnt}, exp_cnt);
    if (e_stall && exp_cnt < 65535)
      exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst.stall", {31'd0, stall}, 0);
    checkOutput("rst.issue", {31'd0, issue}, 0);
    checkOutput("rst.wb_valid", {31'd0, wb_valid}, 0);
    checkOutput("rst.wb_dest", {27'd0, wb_dest}, 0);
    checkOutput("rst.drain_done", {31'd0, drain_done}, 0);
    checkOutput("rst.stall_cnt", {16'd0, stall_cnt}, 0);
    applyStimulus(1, 1, 2, 3, 0);
    #1;
    checkOutput("rst.issue_comb", {31'd0, issue}, 1);
    applyStimulus(0, 0, 0, 0, 0);
    #4 rst = 1'b1;
    @(posedge clk);
    #1;

    // Independent back-to-back pair
    applyStimulus(1, 1, 2, 3, 0); checkCycle("ind0", 0, 1, 0, 0, 0);
    applyStimulus(1, 4, 5, 6, 0); checkCycle("ind1", 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0); checkCycle("ind2", 0, 0, 0, 0, 0);
    checkCycle("ind3", 0, 0, 1, 3, 0);
    checkCycle("ind4", 0, 0, 1, 6, 0);
    checkCycle("ind5", 0, 0, 0, 0, 0);

    // Dependent pair: consumer reads r3 produced the cycle before
    applyStimulus(1, 1, 2, 3, 0); checkCycle("dep0", 0, 1, 0, 0, 0);
    applyStimulus(1, 3, 1, 4, 0);
    for (int i = 1; i <= DEP_STALLS; i++)
      checkCycle("dep_stall", 1, 0, (i == 3), 5'd3, 0);
    checkCycle("dep_issue", 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkCycle("dep_f1", 0, 0, 0, 0, 0);
    checkCycle("dep_f2", 0, 0, 0, 0, 0);
    checkCycle("dep_f3", 0, 0, 1, 4, 0);

    // Register 0 never hazards; then a WAW on r5
    applyStimulus(1, 1, 2, 0, 0); checkCycle("r0_prod", 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 5, 0); checkCycle("r0_cons", 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 2, 5, 0);
    checkCycle("waw1", 1, 0, 0, 0, 0);
    checkCycle("waw2", 1, 0, 1, 0, 0);
    checkCycle("waw3", 1, 0, 1, 5, 0);
    checkCycle("waw_issue", 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkCycle("waw_f1", 0, 0, 0, 0, 0);
    checkCycle("waw_f2", 0, 0, 0, 0, 0);
    checkCycle("waw_f3", 0, 0, 1, 5, 0);

    // Drain after two issues, valid held high throughout
    applyStimulus(1, 1, 2, 8, 0);    checkCycle("drn0", 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 2, 9, 0);    checkCycle("drn1", 0, 1, 0, 0, 0);
    applyStimulus(1, 10, 11, 12, 1); checkCycle("drn2", 1, 0, 0, 0, 0);
    checkCycle("drn3", 1, 0, 1, 8, 0);
    checkCycle("drn4", 1, 0, 1, 9, 0);
    checkCycle("drn5", 1, 0, 0, 0, 0);
    applyStimulus(1, 10, 11, 12, 0); checkCycle("drn6_done", 1, 0, 0, 0, 1);
    checkCycle("drn7_resume", 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkCycle("drn_f1", 0, 0, 0, 0, 0);
    checkCycle("drn_f2", 0, 0, 0, 0, 0);
    checkCycle("drn_f3", 0, 0, 1, 12, 0);

    // Drain on an empty pipe, held through one DONE to force a second drain
    applyStimulus(0, 0, 0, 0, 1);
    checkCycle("edrn0", 0, 0, 0, 0, 0);
    checkCycle("edrn1", 0, 0, 0, 0, 0);
    checkCycle("edrn2", 0, 0, 0, 0, 1);
    checkCycle("edrn3", 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkCycle("edrn4", 0, 0, 0, 0, 1);
    checkCycle("edrn5", 0, 0, 0, 0, 0);

    // Reset with three entries in flight
    applyStimulus(1, 1, 2, 13, 0); checkCycle("rmid0", 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 2, 14, 0); checkCycle("rmid1", 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 2, 15, 0); checkCycle("rmid2", 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rmid.pre_wb_valid", {31'd0, wb_valid}, 1);
    checkOutput("rmid.pre_wb_dest", {27'd0, wb_dest}, 13);
    #1 rst = 1'b0;
    #1;
    checkOutput("rmid.wb_valid", {31'd0, wb_valid}, 0);
    checkOutput("rmid.wb_dest", {27'd0, wb_dest}, 0);
    checkOutput("rmid.stall_cnt", {16'd0, stall_cnt}, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      checkCycle("rmid_post", 0, 0, 0, 0, 0);

    // Saturation: drain held with valid high stalls every cycle
    applyStimulus(1, 1, 2, 3, 1);
    repeat (65535 - exp_cnt + 4) @(posedge clk);
    #1;
    checkOutput("sat.stall", {31'd0, stall}, 1);
    checkOutput("sat.stall_cnt", {16'd0, stall_cnt}, 32'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sat.no_wrap", {16'd0, stall_cnt}, 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_hazard_scheduler.md
ALU_HAZARD_SCHEDULER -- requirements
Module: alu_hazard_scheduler

Interface
REQ-001 Parameter: DEPTH, 3, ALU pipeline stages tracked (stage 1 = issue register, stage DEPTH = writeback).
REQ-002 Parameter: CNT_W, 16, width of stall statistics counter.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 valid  input  1  decoded instruction present this cycle.
REQ-006 opcode  input  7  decoded opcode, passed through on issue.
REQ-007 src1, src2  input  5 each  source register addresses.
REQ-008 dest  input  5  destination register address.
REQ-009 drain  input  1  level request: stop issuing until pipeline empty.
REQ-010 stall  output  1  hold fetch/PC; instruction not accepted this cycle.
REQ-011 issue  output  1  instruction accepted into ALU this cycle.
REQ-012 wb_valid  output  1  stage-DEPTH entry writes back this cycle.
REQ-013 wb_dest  output  5  register written back when wb_valid=1.
REQ-014 drain_done  output  1  one-cycle pulse when drain completes.
REQ-015 stall_cnt  output  CNT_W  saturating count of cycles with stall=1.

Function
REQ-016 Tracker: DEPTH-entry shift chain of {v, dest}; each cycle entry k moves to k+1, stage-1 loads {issue, dest}.
REQ-017 Issue latency: instruction issued cycle N occupies stage 1 at N+1, stage DEPTH at N+DEPTH; wb_valid=1, wb_dest=dest during cycle N+DEPTH.
REQ-018 RAW hazard: valid and any tracked entry with v=1, dest==src1 or dest==src2, dest!=0.
REQ-019 WAW hazard: valid and any tracked entry with v=1, dest==dest input, dest!=0.
REQ-020 Register 0 never causes a hazard (reads or writes).
REQ-021 stall = valid & (hazard | state!=RUN); issue = valid & ~stall; all combinational from current state and inputs.
REQ-022 During stall the chain still advances with a bubble (v=0) in stage 1; hazards clear as producers retire.
REQ-023 FSM states RUN, DRAIN, DONE; reset state RUN.
REQ-024 RUN -> DRAIN when drain=1 (no issue that cycle, even if hazard-free).
REQ-025 DRAIN -> DONE when all DEPTH entries have v=0; drain_done=1 during DONE only.
REQ-026 DONE -> RUN when drain=0, else DONE -> DRAIN (drain_done pulses once per completed drain).
REQ-027 drain asserted with pipeline already empty: RUN -> DRAIN -> DONE, drain_done two cycles after drain rises.
REQ-028 stall_cnt increments each cycle stall=1, saturates at all-ones, never wraps.
REQ-029 Simultaneous writeback of register R and new instruction reading R: hazard still flagged that cycle (no same-cycle write-through) unless forwarding per REQ-034.

Reset
REQ-030 rst=0 immediately clears all tracker v bits, forces state RUN, stall_cnt=0, independent of clk.
REQ-031 Outputs under reset: issue=0 unless valid and no hazard (chain empty), stall=0 with valid=0, wb_valid=0, wb_dest=0, drain_done=0.
REQ-032 Reset mid-operation discards in-flight entries; no writeback reported for them after reset release.
REQ-033 Reset deassertion takes effect at first rising clk after rst returns to 1.

Configuration
REQ-034 Macro ALU_HAZARD_FWD_EN defined: ALU forwards stage 2..DEPTH results; RAW compare (REQ-018) uses stage 1 only; WAW unchanged.
REQ-035 Macro undefined: RAW compare against all DEPTH stages, no forwarding assumed.

Verification
REQ-036 Back-to-back independent: r3=r1+r2 then r6=r4+r5 -> issue=1 both cycles, stall_cnt=0, wb_dest=3 then 6 at N+3, N+4.
REQ-037 Dependent pair, no FWD: r3=r1+r2 then r4=r3+r1 -> second stalls 3 cycles, issues at N+4, stall_cnt=3.
REQ-038 Same pair with ALU_HAZARD_FWD_EN -> second stalls 1 cycle, issues at N+2, stall_cnt=1.
REQ-039 dest=0 producer followed by src1=0 consumer -> no stall, issue both cycles.
REQ-040 drain=1 after 2 issues -> issue=0 from drain cycle, drain_done single pulse when last entry retires; drop drain -> RUN, issue resumes next cycle.
REQ-041 rst=0 mid-cycle with 3 entries in flight -> wb_valid=0 immediately, no wb of old entries after release, stall_cnt=0.
